// File: rtl/par_buffer_reader_pkg.sv
// Shared types and helpers for the parallel-word buffer reader.
package par_buffer_reader_pkg;

   // Output register occupancy: EMPTY means dout holds no deliverable beat.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rd_state_e;

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/par_buffer_reader_circ_buffer_mem.sv
// Circular word storage: PAR_WRITE-wide write port, PAR_READ-wide
// combinational read port, addresses wrap modulo MEM_SIZE.
module circ_buffer_mem #(
   parameter int unsigned SIZE        = 16,
   parameter int unsigned MEM_SIZE    = 8,
   parameter int unsigned PAR_WRITE   = 4,
   parameter int unsigned PAR_READ    = 2,
   parameter int unsigned ADDRES_SIZE = $clog2(MEM_SIZE)
) (
   input  logic                      clk_i,
   input  logic                      wr_en_i,
   input  logic [ADDRES_SIZE-1:0]    wr_addr_i,
   input  logic [SIZE*PAR_WRITE-1:0] wr_data_i,
   input  logic [ADDRES_SIZE-1:0]    rd_addr_i,
   output logic [SIZE*PAR_READ-1:0]  rd_data_o
);

   logic [SIZE-1:0] mem_q [MEM_SIZE];

   // Store all words of an accepted beat; pointer arithmetic wraps naturally.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int unsigned k = 0; k < PAR_WRITE; k++) begin
            mem_q[wr_addr_i + ADDRES_SIZE'(k)] <= wr_data_i[k*SIZE +: SIZE];
         end
      end
   end

   // Present PAR_READ consecutive words starting at the read pointer.
   always_comb begin
      rd_data_o = '0;
      for (int unsigned j = 0; j < PAR_READ; j++) begin
         rd_data_o[j*SIZE +: SIZE] = mem_q[rd_addr_i + ADDRES_SIZE'(j)];
      end
   end

endmodule

// File: rtl/par_buffer_reader.sv
// Parallel-word buffer reader: accepts PAR_WRITE-word beats into a circular
// memory and emits PAR_READ-word beats through a registered output stage.
module par_buffer_reader
   import par_buffer_reader_pkg::*;
#(
   parameter int unsigned SIZE        = 16,
   parameter int unsigned MEM_SIZE    = 8,
   parameter int unsigned PAR_WRITE   = 4,
   parameter int unsigned PAR_READ    = 2,
   parameter int unsigned ADDRES_SIZE = $clog2(MEM_SIZE),
   parameter int unsigned CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SIZE*PAR_WRITE-1:0] din,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SIZE*PAR_READ-1:0]  dout,
   output logic [CNT_SIZE-1:0]       count
);

   // Elaboration-time legality of the geometry.
   if (!is_pow2(MEM_SIZE) || MEM_SIZE < 2) begin : g_bad_mem_size
      $error("par_buffer_reader: MEM_SIZE must be a power of two >= 2");
   end
   if (MEM_SIZE < PAR_WRITE || MEM_SIZE < PAR_READ || PAR_WRITE == 0 || PAR_READ == 0) begin : g_bad_par
      $error("par_buffer_reader: PAR_WRITE/PAR_READ must be in 1..MEM_SIZE");
   end

   localparam logic [CNT_SIZE-1:0]    MEM_C  = CNT_SIZE'(MEM_SIZE);
   localparam logic [CNT_SIZE-1:0]    PW_C   = CNT_SIZE'(PAR_WRITE);
   localparam logic [CNT_SIZE-1:0]    PR_C   = CNT_SIZE'(PAR_READ);
   localparam logic [ADDRES_SIZE-1:0] PW_A   = ADDRES_SIZE'(PAR_WRITE);
   localparam logic [ADDRES_SIZE-1:0] PR_A   = ADDRES_SIZE'(PAR_READ);

   rd_state_e                  state_q;
   logic                       out_valid_q;
   logic [SIZE*PAR_READ-1:0]   dout_q;
   logic [ADDRES_SIZE-1:0]     wptr_q, wptr_d;
   logic [ADDRES_SIZE-1:0]     rptr_q, rptr_d;
   logic [CNT_SIZE-1:0]        count_q, count_d;
   logic [CNT_SIZE-1:0]        free_w;
   logic                       wr_fire;
   logic                       avail;
   logic                       load;
   logic [SIZE*PAR_READ-1:0]   rd_data;

   circ_buffer_mem #(
      .SIZE        (SIZE),
      .MEM_SIZE    (MEM_SIZE),
      .PAR_WRITE   (PAR_WRITE),
      .PAR_READ    (PAR_READ),
      .ADDRES_SIZE (ADDRES_SIZE)
   ) u_mem (
      .clk_i     (clk),
      .wr_en_i   (wr_fire),
      .wr_addr_i (wptr_q),
      .wr_data_i (din),
      .rd_addr_i (rptr_q),
      .rd_data_o (rd_data)
   );

   // Handshake decode and next pointer/occupancy values; load sees only the
   // pre-write count so a beat is never read in the cycle it is written.
   always_comb begin
      free_w   = MEM_C - count_q;
      in_ready = rst_n && (free_w >= PW_C);
      wr_fire  = in_valid && in_ready;
      avail    = (count_q >= PR_C);
      load     = 1'b0;
      case (state_q)
         ST_EMPTY: load = avail;
         ST_FULL:  load = out_ready && avail;
         default:  load = 1'b0;
      endcase
      wptr_d  = wr_fire ? (wptr_q + PW_A) : wptr_q;
      rptr_d  = load    ? (rptr_q + PR_A) : rptr_q;
      count_d = count_q + (wr_fire ? PW_C : '0) - (load ? PR_C : '0);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Output register state machine; dout holds its last value when emptied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (load) begin
                  dout_q      <= rd_data;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  if (load) begin
                     dout_q <= rd_data;
                  end else begin
                     out_valid_q <= 1'b0;
                     state_q     <= ST_EMPTY;
                  end
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign count     = count_q;

endmodule

// File: tb/tb_par_buffer_reader.sv
// Directed bench for par_buffer_reader with a word-queue reference model
// compared every cycle plus literal checkpoints from hand calculation.
module tb_par_buffer_reader;

   localparam int unsigned SIZE      = 16;
   localparam int unsigned MEM_SIZE  = 8;
   localparam int unsigned PAR_WRITE = 4;
   localparam int unsigned PAR_READ  = 2;
   localparam int unsigned CNT_SIZE  = $clog2(MEM_SIZE + 1);

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      in_valid;
   logic                      in_ready;
   logic [SIZE*PAR_WRITE-1:0] din;
   logic                      out_valid;
   logic                      out_ready;
   logic [SIZE*PAR_READ-1:0]  dout;
   logic [CNT_SIZE-1:0]       count;

   par_buffer_reader #(
      .SIZE      (SIZE),
      .MEM_SIZE  (MEM_SIZE),
      .PAR_WRITE (PAR_WRITE),
      .PAR_READ  (PAR_READ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .count     (count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is simply an ordered list of words.
   logic [SIZE-1:0]           m_q[$];
   logic                      m_valid = 1'b0;
   logic [SIZE*PAR_READ-1:0]  m_dout  = '0;
   bit                        chk_en  = 1'b0;

   always @(posedge clk) begin
      int  pre;
      bit  acc;
      bit  ld;
      pre = m_q.size();
      if (!rst_n) begin
         m_q.delete();
         m_valid = 1'b0;
         m_dout  = '0;
      end else begin
         acc = in_valid && ((MEM_SIZE - pre) >= PAR_WRITE);
         ld  = 1'b0;
         if (!m_valid || out_ready) begin
            ld = (pre >= PAR_READ);
            if (!ld) m_valid = 1'b0;
         end
         if (ld) begin
            for (int j = 0; j < PAR_READ; j++) m_dout[j*SIZE +: SIZE] = m_q.pop_front();
            m_valid = 1'b1;
         end
         if (acc) begin
            for (int k = 0; k < PAR_WRITE; k++) m_q.push_back(din[k*SIZE +: SIZE]);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_in_ready", 64'(in_ready), 64'(rst_n && ((MEM_SIZE - m_q.size()) >= PAR_WRITE)));
         check("model_out_valid", 64'(out_valid), 64'(m_valid));
         check("model_dout", 64'(dout), 64'(m_dout));
         check("model_count", 64'(count), 64'(m_q.size()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int base);
      for (int k = 0; k < PAR_WRITE; k++) din[k*SIZE +: SIZE] = SIZE'(base + k);
   endtask

   initial begin
      int got[$];
      int b;
      int budget;

      // Reset with in_valid asserted.
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; set_beat(16'h0055);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'h0);
      step();
      chk_en = 1'b1;
      check("rst_in_ready2", 64'(in_ready), 64'h0);
      step();
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_dout", 64'(dout), 64'h0);
      check("rst_in_ready_after", 64'(in_ready), 64'h1);

      // Single beat.
      in_valid = 1'b1; set_beat(1); out_ready = 1'b1;
      step(); in_valid = 1'b0;
      check("sb_count4", 64'(count), 64'd4);
      step();
      check("sb_valid", 64'(out_valid), 64'h1);
      check("sb_dout0", 64'(dout), 64'h0002_0001);
      check("sb_count2", 64'(count), 64'd2);
      step();
      check("sb_dout1", 64'(dout), 64'h0004_0003);
      check("sb_count0", 64'(count), 64'd0);
      step();
      check("sb_empty", 64'(out_valid), 64'h0);

      // Fill with consumer stalled.
      out_ready = 1'b0; in_valid = 1'b1; set_beat(1);
      step(); in_valid = 1'b0;
      step();
      check("full_count2", 64'(count), 64'd2);
      in_valid = 1'b1; set_beat(5);
      step();
      check("full_count6", 64'(count), 64'd6);
      check("full_in_ready", 64'(in_ready), 64'h0);
      set_beat(9);
      step(); step();
      check("full_hold_count", 64'(count), 64'd6);
      check("full_hold_dout", 64'(dout), 64'h0002_0001);
      check("full_hold_valid", 64'(out_valid), 64'h1);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check("drain_count", 64'(count), 64'd0);
      check("drain_valid", 64'(out_valid), 64'h0);

      // Wrap-around streaming of words 1..24.
      b = 0; budget = 200;
      while ((b < 6 || got.size() < 24) && budget > 0) begin
         in_valid = (b < 6);
         if (b < 6) set_beat(1 + 4*b);
         if (out_valid && out_ready) begin
            got.push_back(int'(dout[SIZE-1:0]));
            got.push_back(int'(dout[2*SIZE-1:SIZE]));
         end
         if (in_valid && in_ready) b++;
         step();
         budget--;
      end
      in_valid = 1'b0;
      check("stream_done", 64'(budget > 0), 64'h1);
      for (int i = 0; i < got.size(); i++) check($sformatf("stream_word%0d", i), 64'(got[i]), 64'(i + 1));
      for (int i = 0; i < 4; i++) step();

      // Simultaneous write and load with count=4 and out_valid=1.
      out_ready = 1'b0; in_valid = 1'b1; set_beat(16'h11);
      step(); in_valid = 1'b0;
      step();
      in_valid = 1'b1; set_beat(16'h15);
      step(); in_valid = 1'b0; out_ready = 1'b1;
      step(); out_ready = 1'b0;
      check("sim_pre_count", 64'(count), 64'd4);
      check("sim_pre_dout", 64'(dout), 64'h0014_0013);
      in_valid = 1'b1; out_ready = 1'b1; set_beat(16'h19);
      step(); in_valid = 1'b0; out_ready = 1'b0;
      check("sim_count6", 64'(count), 64'd6);
      check("sim_dout", 64'(dout), 64'h0016_0015);
      check("sim_valid", 64'(out_valid), 64'h1);

      // Reset in the middle of operation.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mrst_valid", 64'(out_valid), 64'h0);
      check("mrst_count", 64'(count), 64'd0);
      in_valid = 1'b1; out_ready = 1'b1; set_beat(16'hA1);
      step(); in_valid = 1'b0;
      step();
      check("mrst_first_dout", 64'(dout), 64'h00A2_00A1);
      check("mrst_first_valid", 64'(out_valid), 64'h1);
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
